// File: rtl/dclk_set_ctrl_pkg.sv
// Shared definitions for the digital-clock time-setting controller:
// state encoding, field select codes, twinkle bit positions, key indices.
package dclk_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } set_state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_MIN  = 2'b01;
  localparam logic [1:0] FIELD_HOUR = 2'b10;

  localparam int TWK_HOUR = 2;
  localparam int TWK_MIN  = 1;
  localparam int TWK_SEC  = 0;

  localparam int KEY_SET = 0;
  localparam int KEY_UP  = 1;
  localparam int KEY_DN  = 2;

  // Field being edited in a given state
  function automatic logic [1:0] field_of(input set_state_t st);
    logic [1:0] f;
    f = FIELD_NONE;
    if (st == SET_HOUR) f = FIELD_HOUR;
    else if (st == SET_MIN) f = FIELD_MIN;
    return f;
  endfunction

  // Blink mask for the tube pairs in a given state
  function automatic logic [2:0] twinkle_of(input set_state_t st);
    logic [2:0] m;
    m = 3'b000;
    if (st == SET_HOUR) m[TWK_HOUR] = 1'b1;
    else if (st == SET_MIN) m[TWK_MIN] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/dclk_key_debounce.sv
// One front-panel key: 2-flop synchroniser, tick-based debounce, and a
// one-clk press event on the debounced released->pressed transition.
module dclk_key_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1k,
  input  logic key_n,
  output logic pressed,
  output logic press_p
);

  localparam int CW = $clog2(DEB_MS + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;
  logic          synced_pressed;

  // Key is active-low; idle (reset) level of the synchroniser is released
  assign synced_pressed = ~sync2_reg;

  // Bring the asynchronous raw key into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a level change only after DEB_MS consecutive differing ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (tick_1k) begin
        if (synced_pressed != level_reg) begin
          if (cnt_reg >= CW'(DEB_MS - 1)) begin
            level_reg <= ~level_reg;
            cnt_reg   <= '0;
            press_reg <= ~level_reg;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end
    end
  end

  assign pressed = level_reg;
  assign press_p = press_reg;

endmodule

// File: rtl/dclk_set_ctrl.sv
// Time-setting controller: debounces set/up/down, sequences
// RUN -> SET_HOUR -> SET_MIN -> RUN, and issues inc/dec pulses with
// auto-repeat plus an idle timeout back to RUN.
module dclk_set_ctrl #(
  parameter int DEB_MS  = 20,
  parameter int HOLD_MS = 1000,
  parameter int REP_MS  = 200,
  parameter int IDLE_MS = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1k,
  input  logic       key_set_N,
  input  logic       key_up_N,
  input  logic       key_dn_N,
  output logic       run_en,
  output logic [1:0] field_sel,
  output logic       inc_p,
  output logic       dec_p,
  output logic       sec_clr_p,
  output logic [2:0] twinkle_en
);

  import dclk_set_ctrl_pkg::*;

  localparam int HCW = $clog2(HOLD_MS + 1);
  localparam int RCW = $clog2(REP_MS + 1);
  localparam int ICW = $clog2(IDLE_MS + 1);

  logic [2:0] key_raw_n;
  logic [2:0] key_lvl;
  logic [2:0] key_press;
  logic       set_level_unused;

  set_state_t     state_reg;
  set_state_t     state_next;
  logic           sec_clr_next;
  logic           run_en_reg;
  logic [1:0]     field_sel_reg;
  logic [2:0]     twinkle_reg;
  logic           inc_p_reg;
  logic           dec_p_reg;
  logic           sec_clr_p_reg;

  logic [HCW-1:0] hold_cnt_reg;
  logic [RCW-1:0] rep_cnt_reg;
  logic           rep_p_reg;
  logic [ICW-1:0] idle_cnt_reg;

  logic in_setting;
  logic set_press;
  logic any_press;
  logic single_up;
  logic single_dn;
  logic single_held;
  logic hold_done;
  logic rep_due;
  logic idle_expire;
  logic up_fire;
  logic dn_fire;

  assign key_raw_n = {key_dn_N, key_up_N, key_set_N};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      dclk_key_debounce #(
        .DEB_MS (DEB_MS)
      ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .tick_1k (tick_1k),
        .key_n   (key_raw_n[gi]),
        .pressed (key_lvl[gi]),
        .press_p (key_press[gi])
      );
    end
  endgenerate

  // Only the press event of the set key matters; its held level does not
  assign set_level_unused = key_lvl[KEY_SET];

  assign in_setting  = (state_reg != RUN);
  assign set_press   = key_press[KEY_SET];
  assign any_press   = |key_press;
  // Both up and down held cancel each other out
  assign single_up   = key_lvl[KEY_UP] & ~key_lvl[KEY_DN];
  assign single_dn   = key_lvl[KEY_DN] & ~key_lvl[KEY_UP];
  assign single_held = single_up | single_dn;
  assign hold_done   = (hold_cnt_reg == HCW'(HOLD_MS));
  assign rep_due     = hold_done ? (rep_cnt_reg == RCW'(REP_MS - 1))
                                 : (hold_cnt_reg == HCW'(HOLD_MS - 1));
  assign idle_expire = in_setting & tick_1k & ~any_press & ~rep_p_reg &
                       (idle_cnt_reg == ICW'(IDLE_MS - 1));
  // A set press in the same cycle wins over any up/down activity
  assign up_fire = in_setting & ~set_press & single_up &
                   (key_press[KEY_UP] | rep_p_reg);
  assign dn_fire = in_setting & ~set_press & single_dn &
                   (key_press[KEY_DN] | rep_p_reg);

  // Hold timer: first repeat after HOLD_MS ticks, then every REP_MS ticks
  always_ff @(posedge clk) begin
    if (rst || !in_setting || !single_held || set_press) begin
      hold_cnt_reg <= '0;
      rep_cnt_reg  <= '0;
      rep_p_reg    <= 1'b0;
    end else begin
      rep_p_reg <= 1'b0;
      if (tick_1k) begin
        rep_p_reg <= rep_due;
        if (!hold_done) begin
          hold_cnt_reg <= hold_cnt_reg + HCW'(1);
        end else if (rep_due) begin
          rep_cnt_reg <= '0;
        end else begin
          rep_cnt_reg <= rep_cnt_reg + RCW'(1);
        end
      end
    end
  end

  // Idle timer: restarted by any press or repeat pulse, saturates at IDLE_MS
  always_ff @(posedge clk) begin
    if (rst || !in_setting || any_press || rep_p_reg) begin
      idle_cnt_reg <= '0;
    end else if (tick_1k && (idle_cnt_reg != ICW'(IDLE_MS))) begin
      idle_cnt_reg <= idle_cnt_reg + ICW'(1);
    end
  end

  // Next setting state and the seconds-clear request on a set-key exit
  always_comb begin
    state_next   = state_reg;
    sec_clr_next = 1'b0;
    case (state_reg)
      RUN: begin
        if (set_press) state_next = SET_HOUR;
      end
      SET_HOUR: begin
        if (set_press)        state_next = SET_MIN;
        else if (idle_expire) state_next = RUN;
      end
      SET_MIN: begin
        if (set_press) begin
          state_next   = RUN;
          sec_clr_next = 1'b1;
        end else if (idle_expire) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Setting FSM with registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      run_en_reg    <= 1'b1;
      field_sel_reg <= FIELD_NONE;
      twinkle_reg   <= 3'b000;
      inc_p_reg     <= 1'b0;
      dec_p_reg     <= 1'b0;
      sec_clr_p_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      run_en_reg    <= (state_next == RUN);
      field_sel_reg <= field_of(state_next);
      twinkle_reg   <= twinkle_of(state_next);
      inc_p_reg     <= up_fire;
      dec_p_reg     <= dn_fire;
      sec_clr_p_reg <= sec_clr_next;
    end
  end

  assign run_en     = run_en_reg;
  assign field_sel  = field_sel_reg;
  assign twinkle_en = twinkle_reg;
  assign inc_p      = inc_p_reg;
  assign dec_p      = dec_p_reg;
  assign sec_clr_p  = sec_clr_p_reg;

endmodule

// File: doc/dclk_set_ctrl.md
Name: dclk_set_ctrl

Overview:
- Time-setting controller for the digital clock. Debounces the three front-panel keys (set/up/down) on the 1 kHz enable tick and sequences the setting mode RUN -> SET_HOUR -> SET_MIN -> RUN.
- Generates single-cycle increment/decrement pulses, with auto-repeat on long press, for the selected field.
- Drives the twinkle enables and run-enable consumed by the clock logic and the tube driver.

Parameters:
- DEB_MS, 20: consecutive stable ticks required to accept a key level change.
- HOLD_MS, 1000: ticks a key must be held before auto-repeat starts.
- REP_MS, 200: ticks between auto-repeat pulses.
- IDLE_MS, 10000: ticks without any accepted press before a setting state returns to RUN.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- tick_1k  input  1  one-clk enable pulse at 1 kHz; all timing counts these ticks.
- key_set_N  input  1  raw set key, active-low, asynchronous/bouncing.
- key_up_N  input  1  raw up key, active-low.
- key_dn_N  input  1  raw down key, active-low.
- run_en  output  1  1 = timekeeping counts; 0 while setting.
- field_sel  output  2  00 none, 01 minute, 10 hour.
- inc_p  output  1  one-clk increment pulse for the selected field.
- dec_p  output  1  one-clk decrement pulse for the selected field.
- sec_clr_p  output  1  one-clk pulse: clear seconds on exit via set key.
- twinkle_en  output  3  [2] hour, [1] minute, [0] second tube pair blink enables.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). On rst: state RUN, run_en=1, field_sel=00, inc_p/dec_p/sec_clr_p=0, twinkle_en=000, all counters 0, debounced levels = released.
- Input sync: each raw key passes through a 2-flop synchroniser on clk.
- Debounce: on each tick_1k, if the synced level differs from the debounced level, increment the counter; otherwise clear it. When the counter reaches DEB_MS, flip the debounced level and clear the counter. A press event is the released->pressed transition of the debounced level.
- FSM transitions, only on set press:
  - RUN -> SET_HOUR
  - SET_HOUR -> SET_MIN
  - SET_MIN -> RUN, with sec_clr_p=1 on the cycle the state changes.
- Outputs per state:
  - RUN: run_en=1, field_sel=00, twinkle=000; up/down ignored, no inc/dec.
  - SET_HOUR: run_en=0, field_sel=10, twinkle=100.
  - SET_MIN: run_en=0, field_sel=01, twinkle=010.
- Up/down in a setting state:
  - A press event gives inc_p (up) or dec_p (down) on the next clk.
  - While held, a hold counter counts ticks. At HOLD_MS emit a pulse, then a further pulse every REP_MS ticks until release.
- Simultaneous events:
  - Up and down both debounced-pressed: no pulses, hold counter cleared; counting resumes after one is released.
  - Set press in the same cycle as an up/down event: set wins, the inc/dec is dropped, and the hold counter is cleared.
- Idle timeout: in a setting state, the idle counter counts ticks and clears on any press event (set/up/down) or auto-repeat pulse. At IDLE_MS go to RUN without sec_clr_p.
- Latency: press event to pulse/state change is 1 clk; all outputs are registered.
- Counter widths are sized by $clog2 of the parameter and saturate, never wrap.
- Reset mid-setting returns to RUN immediately. Pulses in flight are suppressed.

Decomposition:
- Shared package: state encoding (RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2), field_sel codes, twinkle bit indices (HOUR=2, MIN=1, SEC=0).
- Sub-module dclk_key_debounce (synchroniser + debounce + press-event output), instantiated three times.

Test Plan:
All cases use DEB_MS=4, HOLD_MS=20, REP_MS=5, IDLE_MS=100, with tick_1k every 10 clk.
- Reset then idle 50 ticks -> run_en=1, field_sel=00, twinkle=000, no pulses.
- Set key low with 3-tick chatter, then stable -> exactly one transition to SET_HOUR, 1 clk after the 4th stable tick; twinkle=100, run_en=0.
- In SET_HOUR, hold up for 36 ticks -> inc_p pulses at press, +20, +25, +30, +35 ticks (5 total); dec_p never asserted.
- In SET_MIN, press set -> state RUN, sec_clr_p high exactly 1 clk, run_en=1 next clk.
- In SET_MIN, no keys for 100 ticks -> RUN, sec_clr_p stays 0.
- Up and down both held 40 ticks in SET_HOUR -> zero inc_p/dec_p; assert rst mid-sequence -> all outputs at reset values the following clk.
